// File: rtl/regfile_pkg.sv
// Shared defaults, sequencer state encoding and port-slicing helper for the
// multi-port register file (optional feature macro: REGFILE_BYPASS_EN).
package regfile_pkg;

  localparam int unsigned REGFILE_DEFAULT_WIDTH = 32;
  localparam int unsigned REGFILE_DEFAULT_DEPTH = 32;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef enum logic [0:0] {
    CLEAR = ST_CLEAR,
    READY = ST_READY
  } regfile_state_e;

  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks clr_idx over 1..DEPTH-1 after reset or on request,
// zeroing one storage entry per cycle; busy is high for the whole walk.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = REGFILE_DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

  regfile_state_e state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;

  // Next-state logic: terminal compare against DEPTH-1, so the counter never wraps
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        if (idx_q == IDX_LAST) begin
          state_d = READY;
          idx_d   = IDX_FIRST;
        end else begin
          state_d = CLEAR;
          idx_d   = idx_q + AW'(1);
        end
      end
      READY: begin
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = IDX_FIRST;
        end else begin
          state_d = READY;
          idx_d   = idx_q;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = IDX_FIRST;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= IDX_FIRST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NREAD combinational read ports, a valid/ready
// write port and a sequenced hardware clear. REGFILE_BYPASS_EN adds write-through forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = REGFILE_DEFAULT_WIDTH,
  parameter int unsigned DEPTH = REGFILE_DEFAULT_DEPTH,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clear_req,
  output logic                   busy,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data
);

  logic          busy_s;
  logic          clr_we_s;
  logic [AW-1:0] clr_addr_s;
  logic          wr_fire_s;

  // Register 0 is hardwired, so only entries 1..DEPTH-1 exist
  logic [WIDTH-1:0] mem_q [1:DEPTH-1];

  regfile_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy_s),
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s)
  );

  assign busy      = busy_s;
  assign wr_ready  = ~busy_s;
  assign wr_fire_s = wr_valid && wr_ready && (wr_addr != {AW{1'b0}});

  // Storage update: clear has exclusive access while busy
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_q[clr_addr_s] <= {WIDTH{1'b0}};
    end else if (wr_fire_s) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0]    addr_s;
    logic [WIDTH-1:0] data_s;

    assign addr_s = rd_addr[port_lsb(g, AW) +: AW];

    // Read mux: busy and register 0 force zero ahead of any stored value
    always_comb begin
      if (busy_s || (addr_s == {AW{1'b0}})) begin
        data_s = {WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (wr_fire_s && (wr_addr == addr_s)) begin
        data_s = wr_data;
`endif
      end else begin
        data_s = mem_q[addr_s];
      end
    end

    assign rd_data[port_lsb(g, WIDTH) +: WIDTH] = data_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_regfile_mp;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   wr_valid = 1'b0;
  logic                   wr_ready;
  logic [AW-1:0]          wr_addr = '0;
  logic [WIDTH-1:0]       wr_data = '0;
  logic                   clear_req = 1'b0;
  logic                   busy;
  logic [NREAD*AW-1:0]    rd_addr = '0;
  logic [NREAD*WIDTH-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents and remaining busy cycles
  logic [WIDTH-1:0] model [DEPTH];
  int               busy_left;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear_req (clear_req),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a);
    if (rst || busy_left > 0 || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_valid && wr_addr == a) return wr_data;
`endif
    return model[a];
  endfunction

  function automatic logic [WIDTH-1:0] port_data(input int p);
    return rd_data[p*WIDTH +: WIDTH];
  endfunction

  function automatic logic [AW-1:0] port_addr(input int p);
    return rd_addr[p*AW +: AW];
  endfunction

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Apply the spec rules for the coming edge to the model, then advance one clock.
  task automatic edge_step();
    if (!rst) begin
      if (busy_left > 0) begin
        busy_left--;
      end else begin
        if (wr_valid && wr_addr != '0) model[wr_addr] = wr_data;
        if (clear_req) begin
          busy_left = DEPTH - 1;
          model_zero();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int busy_cycles;
    rst = 1'b1;
    busy_left = DEPTH - 1;
    model_zero();
    for (int c = 0; c < 3; c++) begin
      rd_addr = NREAD*AW'($urandom);
      #1;
      n_checks++;
      if (busy !== 1'b1 || wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hs: busy=%b wr_ready=%b, required busy=1 wr_ready=0", busy, wr_ready);
      end
      n_checks++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL reset_rd: rd_data=%h, required 0", rd_data);
      end
      edge_step();
    end
    rst = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 40 && busy_left > 0; c++) begin
      rd_addr = NREAD*AW'($urandom);
      #1;
      if (busy === 1'b1) busy_cycles++;
      n_checks++;
      if (wr_ready !== 1'b0 || rd_data !== '0) begin
        n_fail++;
        $display("FAIL init_clear: wr_ready=%b rd_data=%h, required 0 and 0", wr_ready, rd_data);
      end
      edge_step();
    end
    n_checks++;
    if (busy_cycles != DEPTH - 1 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_busy_len: busy cycles=%0d busy=%b, required %0d and busy=0", busy_cycles, busy, DEPTH - 1);
    end
    for (int i = 1; i < DEPTH; i += 2) begin
      rd_addr = {AW'((i + 1) % DEPTH), AW'(i)};
      #1;
      n_checks++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL init_zero x%0d: rd_data=%h, required 0", i, rd_data);
      end
    end
  endtask

  task automatic test_write_read();
    wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEADBEEF;
    edge_step();
    wr_addr = AW'(0); wr_data = 32'h0000_1234;
    edge_step();
    wr_valid = 1'b0;
    rd_addr = {AW'(0), AW'(5)};
    #1;
    n_checks++;
    if (port_data(0) !== 32'hDEADBEEF || port_data(0) !== exp_rd(AW'(5))) begin
      n_fail++;
      $display("FAIL wr_rd_x5: got %h, required %h", port_data(0), 32'hDEADBEEF);
    end
    n_checks++;
    if (port_data(1) !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_rd_x0: got %h, required 0", port_data(1));
    end
  endtask

  task automatic test_backpressure();
    int waited;
    clear_req = 1'b1;
    edge_step();
    clear_req = 1'b0;
    wr_valid = 1'b1; wr_addr = AW'(7); wr_data = 32'hA5A5A5A5;
    waited = 0;
    #1;
    while (wr_ready !== 1'b1 && waited < 64) begin
      n_checks++;
      if (wr_ready !== (busy_left == 0)) begin
        n_fail++;
        $display("FAIL bp_ready: wr_ready=%b, required %b", wr_ready, busy_left == 0);
      end
      edge_step();
      waited++;
    end
    n_checks++;
    if (waited != DEPTH - 1) begin
      n_fail++;
      $display("FAIL bp_wait: waited %0d cycles, required %0d", waited, DEPTH - 1);
    end
    edge_step();
    wr_valid = 1'b0;
    rd_addr = {AW'(7), AW'(7)};
    #1;
    n_checks++;
    if (port_data(0) !== 32'hA5A5A5A5 || port_data(1) !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL bp_x7: got %h/%h, required a5a5a5a5", port_data(0), port_data(1));
    end
  endtask

  task automatic test_soft_clear();
    int busy_cycles;
    wr_valid = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      wr_addr = AW'(i); wr_data = WIDTH'(i * 3);
      edge_step();
    end
    wr_valid = 1'b0;
    rd_addr = {AW'(31), AW'(10)};
    #1;
    n_checks++;
    if (port_data(0) !== 32'd30 || port_data(1) !== 32'd93) begin
      n_fail++;
      $display("FAIL fill: got %0d/%0d, required 30/93", port_data(0), port_data(1));
    end
    clear_req = 1'b1; wr_valid = 1'b1; wr_addr = AW'(9); wr_data = 32'hFF;
    #1;
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_wr_accept: wr_ready=%b, required 1", wr_ready);
    end
    edge_step();
    clear_req = 1'b0; wr_valid = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 40 && busy_left > 0; c++) begin
      rd_addr = NREAD*AW'($urandom);
      #1;
      if (busy === 1'b1) busy_cycles++;
      n_checks++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL clr_rd_busy: rd_data=%h, required 0", rd_data);
      end
      edge_step();
    end
    n_checks++;
    if (busy_cycles != DEPTH - 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_busy_len: busy cycles=%0d busy=%b, required %0d and 0", busy_cycles, busy, DEPTH - 1);
    end
    for (int i = 1; i < DEPTH; i++) begin
      rd_addr = {AW'(i), AW'(i)};
      #1;
      n_checks++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL clr_zero x%0d: rd_data=%h, required 0", i, rd_data);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cycles;
    wr_valid = 1'b1; wr_addr = AW'(20); wr_data = 32'h1357_9BDF;
    edge_step();
    wr_valid = 1'b0;
    clear_req = 1'b1;
    edge_step();
    clear_req = 1'b0;
    for (int c = 0; c < 11; c++) edge_step();
    #2;
    rst = 1'b1;
    busy_left = DEPTH - 1;
    model_zero();
    #1;
    n_checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL midclr_rst: busy=%b wr_ready=%b rd_data=%h, required 1/0/0", busy, wr_ready, rd_data);
    end
    edge_step();
    edge_step();
    rst = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 40 && busy_left > 0; c++) begin
      #1;
      if (busy === 1'b1) busy_cycles++;
      edge_step();
    end
    n_checks++;
    if (busy_cycles != DEPTH - 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_len: busy cycles=%0d busy=%b, required %0d and 0", busy_cycles, busy, DEPTH - 1);
    end
    for (int i = 1; i < DEPTH; i += 2) begin
      rd_addr = {AW'((i + 1) % DEPTH), AW'(i)};
      #1;
      n_checks++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL midclr_zero x%0d: rd_data=%h, required 0", i, rd_data);
      end
    end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] exp_same;
    wr_valid = 1'b1; wr_addr = AW'(3); wr_data = 32'h11;
    edge_step();
    wr_data = 32'h55;
    rd_addr = {AW'(3), AW'(3)};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h55;
`else
    exp_same = 32'h11;
`endif
    n_checks++;
    if (port_data(0) !== exp_same || port_data(1) !== exp_same) begin
      n_fail++;
      $display("FAIL bypass_same: got %h/%h, required %h", port_data(0), port_data(1), exp_same);
    end
    edge_step();
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (port_data(0) !== 32'h55 || port_data(1) !== 32'h55) begin
      n_fail++;
      $display("FAIL bypass_next: got %h/%h, required 55", port_data(0), port_data(1));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!(wr_valid && !wr_ready)) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_addr  = AW'($urandom);
        wr_data  = $urandom;
      end
      clear_req = ($urandom_range(0, 59) == 0);
      rd_addr   = NREAD*AW'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[AW +: AW] = wr_addr;
      #1;
      n_checks++;
      if (busy !== (busy_left > 0) || wr_ready !== (busy_left == 0)) begin
        n_fail++;
        $display("FAIL rand_hs c=%0d: busy=%b wr_ready=%b, required busy=%b", c, busy, wr_ready, busy_left > 0);
      end
      for (int p = 0; p < NREAD; p++) begin
        n_checks++;
        if (port_data(p) !== exp_rd(port_addr(p))) begin
          n_fail++;
          $display("FAIL rand_rd c=%0d p=%0d a=%0d: got %h, required %h", c, p, port_addr(p), port_data(p), exp_rd(port_addr(p)));
        end
      end
      edge_step();
    end
    wr_valid = 1'b0;
    clear_req = 1'b0;
  endtask

  initial begin
    busy_left = DEPTH - 1;
    model_zero();
    test_reset();
    test_write_read();
    test_backpressure();
    test_soft_clear();
    test_reset_mid_clear();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
